// File: rtl/mic1_mem_arbiter.sv
// Shares one synchronous single-port RAM between the MIC-1 word port, the MIC-1
// instruction-fetch port and the host loader port using a fixed four-cycle access sequence.
module mic1_mem_arbiter #(
  parameter int ADDR_W = 12,
  parameter int DATA_W = 32
) (
  input  logic              CLK,
  input  logic              RST,
  input  logic              cpu_rd,
  input  logic              cpu_wr,
  input  logic [ADDR_W-1:0] cpu_addr,
  input  logic [DATA_W-1:0] cpu_wdata,
  output logic [DATA_W-1:0] cpu_rdata,
  output logic              cpu_ack,
  input  logic              fetch_rd,
  input  logic [ADDR_W+1:0] fetch_addr,
  output logic [7:0]        fetch_byte,
  output logic              fetch_ack,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_ack,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy
);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_e;
  typedef enum logic [1:0] {SRC_CPU, SRC_FETCH, SRC_HOST} src_e;

  state_e            state_q;
  src_e              src_q;
  logic              lastHost_q;
  logic              isWrite_q;
  logic [1:0]        lane_q;

  logic              cpuWordReq;
  logic              cpuAnyReq;
  logic              anyReq;
  logic              hostWins;
  src_e              src_d;
  logic [ADDR_W-1:0] addr_d;
  logic [DATA_W-1:0] wdata_d;
  logic              we_d;
  logic [7:0]        laneByte;

  // Host and CPU alternate on contention; among CPU ports the word port beats fetch.
  // A simultaneous rd+wr on the word port collapses into a single write.
  always_comb begin
    cpuWordReq = cpu_rd | cpu_wr;
    cpuAnyReq  = cpuWordReq | fetch_rd;
    anyReq     = cpuAnyReq | host_req;
    hostWins   = host_req & (~cpuAnyReq | ~lastHost_q);

    src_d   = SRC_FETCH;
    addr_d  = fetch_addr[ADDR_W+1:2];
    wdata_d = '0;
    we_d    = 1'b0;
    if (hostWins) begin
      src_d   = SRC_HOST;
      addr_d  = host_addr;
      wdata_d = host_wdata;
      we_d    = host_we;
    end else if (cpuWordReq) begin
      src_d   = SRC_CPU;
      addr_d  = cpu_addr;
      wdata_d = cpu_wdata;
      we_d    = cpu_wr;
    end
  end

  // Big-endian lane select: byte address 0 of a word is its most significant byte.
  always_comb begin
    laneByte = mem_rdata[31:24];
    case (lane_q)
      2'd1:    laneByte = mem_rdata[23:16];
      2'd2:    laneByte = mem_rdata[15:8];
      2'd3:    laneByte = mem_rdata[7:0];
      default: laneByte = mem_rdata[31:24];
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RST) begin
      state_q    <= IDLE;
      src_q      <= SRC_CPU;
      lastHost_q <= 1'b0;
      isWrite_q  <= 1'b0;
      lane_q     <= 2'd0;
      mem_en     <= 1'b0;
      mem_we     <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      cpu_ack    <= 1'b0;
      fetch_ack  <= 1'b0;
      host_ack   <= 1'b0;
      cpu_rdata  <= '0;
      host_rdata <= '0;
      fetch_byte <= '0;
    end else begin
      cpu_ack   <= 1'b0;
      fetch_ack <= 1'b0;
      host_ack  <= 1'b0;
      case (state_q)
        IDLE: begin
          if (anyReq) begin
            src_q      <= src_d;
            mem_addr   <= addr_d;
            mem_wdata  <= wdata_d;
            mem_we     <= we_d;
            isWrite_q  <= we_d;
            lane_q     <= fetch_addr[1:0];
            lastHost_q <= hostWins;
            mem_en     <= 1'b1;
            state_q    <= ISSUE;
          end
        end
        ISSUE: begin
          mem_en  <= 1'b0;
          mem_we  <= 1'b0;
          state_q <= WAIT;
        end
        WAIT: begin
          // Writes leave the port's read-data register untouched.
          if (!isWrite_q) begin
            case (src_q)
              SRC_CPU:  cpu_rdata  <= mem_rdata;
              SRC_HOST: host_rdata <= mem_rdata;
              default:  fetch_byte <= laneByte;
            endcase
          end
          case (src_q)
            SRC_CPU:  cpu_ack   <= 1'b1;
            SRC_HOST: host_ack  <= 1'b1;
            default:  fetch_ack <= 1'b1;
          endcase
          state_q <= RESP;
        end
        RESP: begin
          state_q <= IDLE;
        end
        default: begin
          state_q <= IDLE;
        end
      endcase
    end
  end

  assign busy = (state_q != IDLE);

endmodule

// File: doc/mic1_mem_arbiter.md
# mic1_mem_arbiter

Single-port memory arbiter and sequencer for the MIC-1 icebreaker build. It shares one synchronous block RAM between three requesters: the MIC-1 word port (MAR/MDR), the MIC-1 instruction-fetch port (PC/MBR), and the host debug/loader port driven from the UART side. It sits between the MIC-1 core, the UART command engine and the RAM inside `mic1_icebreaker`. It serialises all accesses, guarantees host/CPU fairness, and returns data with a fixed latency.

## Interface
Parameters:
- `ADDR_W`, default 12: word-address width.
- `DATA_W`, default 32: word width. The fetch byte extraction assumes 32.

Ports:
- `CLK`  in  1  system clock. All logic is on the rising edge.
- `RST`  in  1  synchronous, active-high reset.
- `cpu_rd`, `cpu_wr`  in  1 each  MIC-1 word read/write request. Level; held until `cpu_ack`.
- `cpu_addr`  in  ADDR_W  word address (MAR).
- `cpu_wdata`  in  DATA_W  write data (MDR).
- `cpu_rdata`  out  DATA_W  read data. Valid while `cpu_ack`=1.
- `cpu_ack`  out  1  one-cycle completion pulse.
- `fetch_rd`  in  1  instruction byte fetch request. Level.
- `fetch_addr`  in  ADDR_W+2  byte address (PC).
- `fetch_byte`  out  8  fetched byte. Valid while `fetch_ack`=1.
- `fetch_ack`  out  1  one-cycle completion pulse.
- `host_req`, `host_we`  in  1 each  host request and write-enable. Level.
- `host_addr`  in  ADDR_W; `host_wdata`  in  DATA_W.
- `host_rdata`  out  DATA_W; `host_ack`  out  1.
- `mem_en`, `mem_we`  out  1 each  RAM enable and write strobe.
- `mem_addr`  out  ADDR_W; `mem_wdata`  out  DATA_W.
- `mem_rdata`  in  DATA_W  RAM read data. Valid one cycle after the `mem_en` cycle.
- `busy`  out  1  high whenever the state is not IDLE.

## Operation
- FSM states: IDLE -> ISSUE -> WAIT -> RESP -> IDLE. There is no other path except reset.
- IDLE: sample requests and pick a winner.
  - Register the winner id, `mem_addr`, `mem_wdata` and `mem_we`.
  - Go to ISSUE. With no request, stay in IDLE.
- ISSUE: `mem_en`=1 for exactly one cycle. The RAM performs the read or write at the end of this cycle.
- WAIT: capture `mem_rdata` into the winner's read-data register.
  - For a fetch, capture only the selected byte.
- RESP: assert the winner's ack for one cycle, then return to IDLE.
- Only one ack is ever high at a time. Read-data outputs hold their last value between acks.
- Arbitration in IDLE:
  - CPU word beats fetch.
  - Host vs CPU (word or fetch) uses round-robin on the `last_host` flag. Host wins a tie iff `last_host`=0.
  - `last_host` updates on every grant: 1 for a host grant, 0 for any CPU grant.
- Fetch byte lanes are big-endian. Word index = `fetch_addr[ADDR_W+1:2]`.
  - Lane `fetch_addr[1:0]`=0 selects bits 31:24, 1 selects 23:16, 2 selects 15:8, 3 selects 7:0.
  - The byte is zero-extended only by the consumer; the arbiter outputs 8 bits.
- `cpu_rd` and `cpu_wr` both high: treated as a single write, one `cpu_ack`.
- Requests are sampled only in IDLE. A request dropped after grant still completes and is still acked.
- Requester rule: deassert the request (registered) in the cycle after its ack. A request still high in IDLE is a new access.
- A write acks with that port's read-data output unchanged.

## Timing
- Fixed latency. A request first seen high in IDLE at cycle t gives `mem_en`=1 at t+1 and ack=1 at t+3.
- IDLE is re-entered at t+4. Throughput is one access per 4 cycles.
- Reads and writes have identical latency.
- Requests arriving while `busy`=1 wait. The wait is bounded: at most one host access runs before a pending CPU access, and vice versa.
- Reset values:
  - state IDLE, `last_host`=0.
  - all acks 0, `mem_en`=0, `mem_we`=0, `busy`=0.
  - `mem_addr`, `mem_wdata`, `cpu_rdata`, `host_rdata`, `fetch_byte` all 0.
- Reset mid-operation: the FSM is in IDLE in the cycle after `RST` and no ack is issued for the aborted access.
  - If `RST` is sampled at the end of the ISSUE cycle, the RAM still performs that write. The write lands in memory but is unacknowledged.
- A new request in the same cycle as RESP is not seen until IDLE.

## Test plan
- Host write then read: `host_we`=1, addr 0x010, data 0xDEADBEEF. Expect `mem_en` at t+1 and `host_ack` at t+3. A host read of 0x010 then returns `host_rdata`=0xDEADBEEF with the same latency.
- Fetch byte lanes: RAM word 0x005 = 0x11223344. Fetches of byte addresses 0x014..0x017 return 0x11, 0x22, 0x33, 0x44 in order, each with `fetch_ack` exactly 3 cycles after IDLE sampling.
- CPU word vs fetch tie: `cpu_rd` (addr 0x001) and `fetch_rd` (addr 0x008) rise together. Expect `cpu_ack` first at t+3, then `fetch_ack` at t+7. The two acks never overlap.
- Host vs CPU fairness: host and `cpu_rd` both held continuously from reset. Grants alternate host, CPU, host, CPU, starting with host because `last_host`=0. No port waits more than 8 cycles.
- Simultaneous rd/wr: `cpu_rd`=`cpu_wr`=1, addr 0x020, data 0x0000CAFE. Expect one write (`mem_we`=1 in ISSUE), one `cpu_ack`, and RAM[0x020]=0x0000CAFE afterward.
- Reset mid-access:
  - Assert `RST` during WAIT of a host read. Expect no `host_ack`, state IDLE and `host_rdata`=0 the next cycle.
  - Assert `RST` at the end of ISSUE of a write of 0x55 to 0x030. Expect RAM[0x030]=0x55 and no ack.
